// File: rtl/window_feeder_pkg.sv
// Shared types, default sizes and config helpers for the window feeder.
package window_feeder_pkg;

  localparam int unsigned DEF_DW        = 8;
  localparam int unsigned DEF_NUM_BANKS = 32;
  localparam int unsigned DEF_DEPTH     = 64;
  localparam int unsigned DEF_ROWS      = 8;
  localparam int unsigned DEF_KMAX      = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Index width that never collapses to zero.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Stride is 1..3, so division reduces to constant divisors.
  function automatic int div_stride(input int n, input int s);
    case (s)
      2:       return n / 2;
      3:       return n / 3;
      default: return n;
    endcase
  endfunction

  function automatic logic cfg_legal(input int img_w, input int img_h, input int ch,
                                     input int k, input int stride, input int pad,
                                     input int kmax, input int depth);
    int ew;
    int eh;
    ew = img_w + 2 * pad;
    eh = img_h + 2 * pad;
    return !((k == 0) || (k > kmax) || (stride == 0) || (k > ew) || (k > eh) ||
             (ch == 0) || (ch * img_h > depth));
  endfunction

endpackage

// File: rtl/window_addr_gen.sv
// Nested oy/gx/c/ky/kx scan counters and per-lane bank/address/mask decode.
module window_addr_gen
  import window_feeder_pkg::*;
#(
  parameter  int unsigned NUM_BANKS = DEF_NUM_BANKS,
  parameter  int unsigned DEPTH     = DEF_DEPTH,
  parameter  int unsigned ROWS      = DEF_ROWS,
  parameter  int unsigned KMAX      = DEF_KMAX,
  localparam int unsigned BW        = idx_w(NUM_BANKS),
  localparam int unsigned AW        = idx_w(DEPTH),
  localparam int unsigned WW        = BW + 1,
  localparam int unsigned HW        = AW + 1,
  localparam int unsigned KW        = idx_w(KMAX) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_i,
  input  logic                     adv_i,
  input  logic [WW-1:0]            cfg_img_w_i,
  input  logic [HW-1:0]            cfg_img_h_i,
  input  logic [HW-1:0]            cfg_ch_i,
  input  logic [KW-1:0]            cfg_k_i,
  input  logic [1:0]               cfg_stride_i,
  input  logic                     cfg_pad_i,
  output logic [ROWS-1:0][BW-1:0]  bank_c_o,
  output logic [AW-1:0]            addr_c_o,
  output logic [ROWS-1:0]          mask_c_o,
  output logic [ROWS-1:0]          rd_c_o,
  output logic                     first_c_o,
  output logic                     last_c_o,
  output logic                     scan_last_c_o
);

  localparam int unsigned XW = WW + 1;
  localparam int unsigned YW = HW + 1;
  localparam int unsigned GW = XW + idx_w(ROWS) + 1;

  logic [WW-1:0] img_w_q;
  logic [HW-1:0] img_h_q;
  logic [HW-1:0] ch_q;
  logic [KW-1:0] k_q;
  logic [1:0]    stride_q;
  logic          pad_q;
  logic [XW-1:0] out_w_q;
  logic [YW-1:0] out_h_q;

  logic [YW-1:0] oy_q, oy_d;
  logic [GW-1:0] gx_q, gx_d;
  logic [HW-1:0] c_q, c_d;
  logic [KW-1:0] ky_q, ky_d;
  logic [KW-1:0] kx_q, kx_d;

  logic kx_end, ky_end, c_end, gx_end, oy_end, row_ok;

  assign kx_end = (kx_q == k_q - KW'(1));
  assign ky_end = (ky_q == k_q - KW'(1));
  assign c_end  = (c_q == ch_q - HW'(1));
  assign gx_end = (int'(gx_q) + int'(ROWS) >= int'(out_w_q));
  assign oy_end = (oy_q == out_h_q - YW'(1));

  assign first_c_o     = (c_q == '0) && (ky_q == '0) && (kx_q == '0);
  assign last_c_o      = c_end && ky_end && kx_end;
  assign scan_last_c_o = last_c_o && gx_end && oy_end;

  // Innermost kx, then ky, c, lane group, output row.
  always_comb begin
    oy_d = oy_q;
    gx_d = gx_q;
    c_d  = c_q;
    ky_d = ky_q;
    kx_d = kx_q;
    if (load_i) begin
      oy_d = '0;
      gx_d = '0;
      c_d  = '0;
      ky_d = '0;
      kx_d = '0;
    end else if (adv_i) begin
      kx_d = kx_q + KW'(1);
      if (kx_end) begin
        kx_d = '0;
        ky_d = ky_q + KW'(1);
        if (ky_end) begin
          ky_d = '0;
          c_d  = c_q + HW'(1);
          if (c_end) begin
            c_d  = '0;
            gx_d = gx_q + GW'(ROWS);
            if (gx_end) begin
              gx_d = '0;
              oy_d = oy_q + YW'(1);
            end
          end
        end
      end
    end
  end

  // Signed coordinates so the padded border (-1) falls out of range naturally.
  always_comb begin
    int y;
    int x;
    y        = int'(oy_q) * int'(stride_q) + int'(ky_q) - int'(pad_q);
    row_ok   = (y >= 0) && (y < int'(img_h_q));
    addr_c_o = AW'(int'(c_q) * int'(img_h_q) + y);
    bank_c_o = '0;
    mask_c_o = '0;
    rd_c_o   = '0;
    for (int l = 0; l < int'(ROWS); l++) begin
      x           = (int'(gx_q) + l) * int'(stride_q) + int'(kx_q) - int'(pad_q);
      mask_c_o[l] = (int'(gx_q) + l) < int'(out_w_q);
      rd_c_o[l]   = mask_c_o[l] && row_ok && (x >= 0) && (x < int'(img_w_q)) &&
                    (x < int'(NUM_BANKS));
      bank_c_o[l] = BW'(x);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      img_w_q  <= '0;
      img_h_q  <= '0;
      ch_q     <= '0;
      k_q      <= '0;
      stride_q <= '0;
      pad_q    <= 1'b0;
      out_w_q  <= '0;
      out_h_q  <= '0;
      oy_q     <= '0;
      gx_q     <= '0;
      c_q      <= '0;
      ky_q     <= '0;
      kx_q     <= '0;
    end else begin
      if (load_i) begin
        img_w_q  <= cfg_img_w_i;
        img_h_q  <= cfg_img_h_i;
        ch_q     <= cfg_ch_i;
        k_q      <= cfg_k_i;
        stride_q <= cfg_stride_i;
        pad_q    <= cfg_pad_i;
        out_w_q  <= XW'(div_stride(int'(cfg_img_w_i) + 2 * int'(cfg_pad_i) - int'(cfg_k_i),
                                   int'(cfg_stride_i)) + 1);
        out_h_q  <= YW'(div_stride(int'(cfg_img_h_i) + 2 * int'(cfg_pad_i) - int'(cfg_k_i),
                                   int'(cfg_stride_i)) + 1);
      end
      oy_q <= oy_d;
      gx_q <= gx_d;
      c_q  <= c_d;
      ky_q <= ky_d;
      kx_q <= kx_d;
    end
  end

endmodule

// File: rtl/window_feeder.sv
// Banked activation buffer with autonomous sliding-window scan into ROWS array lanes.
// Optional zero-border padding is enabled by defining WINDOW_FEEDER_PAD_EN.
module window_feeder
  import window_feeder_pkg::*;
#(
  parameter  int unsigned DW        = DEF_DW,
  parameter  int unsigned NUM_BANKS = DEF_NUM_BANKS,
  parameter  int unsigned DEPTH     = DEF_DEPTH,
  parameter  int unsigned ROWS      = DEF_ROWS,
  parameter  int unsigned KMAX      = DEF_KMAX,
  localparam int unsigned BW        = idx_w(NUM_BANKS),
  localparam int unsigned AW        = idx_w(DEPTH),
  localparam int unsigned KW        = idx_w(KMAX) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [BW-1:0]      wr_bank,
  input  logic [AW-1:0]      wr_addr,
  input  logic [DW-1:0]      wr_data,
  output logic               wr_ready,
  input  logic               start,
  input  logic [BW:0]        cfg_img_w,
  input  logic [AW:0]        cfg_img_h,
  input  logic [AW:0]        cfg_ch,
  input  logic [KW-1:0]      cfg_k,
  input  logic [1:0]         cfg_stride,
`ifdef WINDOW_FEEDER_PAD_EN
  input  logic               cfg_pad,
`endif
  output logic [DW*ROWS-1:0] out_data,
  output logic [ROWS-1:0]    out_mask,
  output logic               out_first,
  output logic               out_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
  output logic               err
);

  logic pad_c;
`ifdef WINDOW_FEEDER_PAD_EN
  assign pad_c = cfg_pad;
`else
  assign pad_c = 1'b0;
`endif

  state_e state_q, state_d;
  logic [DW*ROWS-1:0] out_data_q, out_data_d;
  logic [ROWS-1:0]    out_mask_q, out_mask_d;
  logic out_first_q, out_first_d, out_last_q, out_last_d, out_valid_q, out_valid_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d, wr_ready_q, wr_ready_d;

  logic [DW-1:0] mem_q [NUM_BANKS][DEPTH];

  logic [ROWS-1:0][BW-1:0] lane_bank_c;
  logic [AW-1:0]           lane_addr_c;
  logic [ROWS-1:0]         lane_mask_c, lane_rd_c;
  logic tap_first_c, tap_last_c, scan_last_c, load_c, adv_c, cfg_ok_c;
  logic [DW*ROWS-1:0]      rd_data_c;

  assign cfg_ok_c = cfg_legal(int'(cfg_img_w), int'(cfg_img_h), int'(cfg_ch), int'(cfg_k),
                              int'(cfg_stride), int'(pad_c), int'(KMAX), int'(DEPTH));

  window_addr_gen #(
    .NUM_BANKS (NUM_BANKS),
    .DEPTH     (DEPTH),
    .ROWS      (ROWS),
    .KMAX      (KMAX)
  ) u_addr_gen (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_i        (load_c),
    .adv_i         (adv_c),
    .cfg_img_w_i   (cfg_img_w),
    .cfg_img_h_i   (cfg_img_h),
    .cfg_ch_i      (cfg_ch),
    .cfg_k_i       (cfg_k),
    .cfg_stride_i  (cfg_stride),
    .cfg_pad_i     (pad_c),
    .bank_c_o      (lane_bank_c),
    .addr_c_o      (lane_addr_c),
    .mask_c_o      (lane_mask_c),
    .rd_c_o        (lane_rd_c),
    .first_c_o     (tap_first_c),
    .last_c_o      (tap_last_c),
    .scan_last_c_o (scan_last_c)
  );

  // Host load path; banks keep their contents across reset.
  always_ff @(posedge clk) begin
    if (wr_en && (state_q == ST_IDLE)) begin
      mem_q[wr_bank][wr_addr] <= wr_data;
    end
  end

  // Lane crossbar: masked or border taps read nothing and drive zero.
  always_comb begin
    rd_data_c = '0;
    for (int l = 0; l < int'(ROWS); l++) begin
      if (lane_rd_c[l]) begin
        rd_data_c[DW*l +: DW] = mem_q[lane_bank_c[l]][lane_addr_c];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_mask_d  = out_mask_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    err_d       = err_q;
    load_c      = 1'b0;
    adv_c       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_ok_c) begin
            state_d = ST_RUN;
            load_c  = 1'b1;
            err_d   = 1'b0;
          end else begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // Issue only when the output register is empty or being drained.
        if (!out_valid_q || out_ready) begin
          adv_c       = 1'b1;
          out_data_d  = rd_data_c;
          out_mask_d  = lane_mask_c;
          out_first_d = tap_first_c;
          out_last_d  = tap_last_c;
          out_valid_d = 1'b1;
          if (scan_last_c) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
          done_d      = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d     = (state_d != ST_IDLE);
    wr_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_data_q  <= '0;
      out_mask_q  <= '0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      wr_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_mask_q  <= out_mask_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      wr_ready_q  <= wr_ready_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_mask  = out_mask_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign wr_ready  = wr_ready_q;

endmodule
